// File: rtl/ref_sig_gen.sv
// ref_sig_gen
// ---------------------------------------------------------------------------
// Programmable DDS square-wave source for the PLL tracking loop's reference
// input. A phase accumulator advances each clk by BASE_INCR * fc plus a signed
// offset (mod). The offset is driven by a linear frequency-ramp sequencer.
// The accumulator MSB is the square wave. A one-shot phase jump can be added
// to the accumulator at any time.
//
// Optional build macro: SIG_GEN_DITHER_EN
//   When defined, a 16-bit LFSR adds a small pseudo-random jitter to the
//   accumulator step. incr_out never includes this jitter.
//   When undefined, the increment is exact.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   fc           frequency multiplier; 0 stops the accumulator (when mod = 0)
//   phase_off    unsigned phase jump amount, added modulo 2^ACC_W
//   phase_load   single-cycle pulse that applies phase_off
//   sweep_start  single-cycle pulse that starts a ramp (ignored while busy)
//   sweep_abort  ends a running ramp at once; mod returns to 0, no done
//   sweep_step   signed increment delta added to mod on each ramp step
//   sweep_steps  number of ramp steps (0 gives an immediate done pulse)
//   busy         ramp sequencer is not idle
//   done         one-cycle pulse when a ramp completes normally
//   sig          square-wave output (accumulator MSB, registered)
//   sync         one-cycle pulse in the same cycle as each sig rising edge
//   incr_out     increment currently in use, without dither (debug)
// ---------------------------------------------------------------------------
module ref_sig_gen #(
  parameter int ACC_W     = 32,
  parameter int BASE_INCR = 8589934,
  parameter int STEP_DIV  = 1000,
  parameter int DWELL_CYC = 2000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       fc,
  input  logic [ACC_W-1:0] phase_off,
  input  logic             phase_load,
  input  logic             sweep_start,
  input  logic             sweep_abort,
  input  logic [ACC_W-1:0] sweep_step,
  input  logic [15:0]      sweep_steps,
  output logic             busy,
  output logic             done,
  output logic             sig,
  output logic             sync,
  output logic [ACC_W-1:0] incr_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RAMP  = 2'd1,
    DWELL = 2'd2
  } rampState_t;

  localparam logic [ACC_W-1:0] BASE       = ACC_W'(BASE_INCR);
  localparam logic [31:0]      DIV_LAST   = 32'(STEP_DIV - 1);
  localparam logic [31:0]      DWELL_LAST = 32'(DWELL_CYC - 1);

  logic [7:0]       fc_q;
  logic [ACC_W-1:0] incr_q;
  logic [ACC_W-1:0] acc_q;
  logic             sig_q;
  logic             sigPrev_q;

  logic [ACC_W-1:0] incrNext;
  logic [ACC_W-1:0] accNext;
  logic [ACC_W-1:0] loadAmt;
  logic [ACC_W-1:0] dither;

  rampState_t       state_q, state_d;
  logic [ACC_W-1:0] mod_q, mod_d;
  logic [31:0]      divCnt_q, divCnt_d;
  logic [15:0]      stepCnt_q, stepCnt_d;
  logic [ACC_W-1:0] stepLatch_q, stepLatch_d;
  logic [15:0]      stepsLatch_q, stepsLatch_d;
  logic             done_q, done_d;

`ifdef SIG_GEN_DITHER_EN
  // Fibonacci LFSR, taps 16,14,13,11. The low byte is shifted into a signed
  // offset of -128..+127 so the jitter is centred on the exact increment.
  logic [15:0] lfsr_q;
  logic        lfsrFb;

  assign lfsrFb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsrFb};
    end
  end

  assign dither = ACC_W'(lfsr_q[7:0]) - ACC_W'(128);
`else
  assign dither = '0;
`endif

  // The increment wraps modulo 2^ACC_W, and mod is treated as two's complement.
  // The accumulator's next value feeds both acc_q and sig_q. As a result, a
  // phase jump shows on sig in the cycle after the pulse. An fc change shows
  // on sig in the third cycle after the change.
  assign incrNext = BASE * ACC_W'(fc_q) + mod_q;
  assign loadAmt  = phase_load ? phase_off : '0;
  assign accNext  = acc_q + incr_q + loadAmt + dither;

  always_ff @(posedge clk) begin
    if (rst) begin
      fc_q      <= '0;
      incr_q    <= '0;
      acc_q     <= '0;
      sig_q     <= 1'b0;
      sigPrev_q <= 1'b0;
    end else begin
      fc_q      <= fc;
      incr_q    <= incrNext;
      acc_q     <= accNext;
      sig_q     <= accNext[ACC_W-1];
      sigPrev_q <= sig_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      mod_q        <= '0;
      divCnt_q     <= '0;
      stepCnt_q    <= '0;
      stepLatch_q  <= '0;
      stepsLatch_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mod_q        <= mod_d;
      divCnt_q     <= divCnt_d;
      stepCnt_q    <= stepCnt_d;
      stepLatch_q  <= stepLatch_d;
      stepsLatch_q <= stepsLatch_d;
      done_q       <= done_d;
    end
  end

  // Abort takes priority over start in every state. In IDLE this means a
  // start that arrives together with an abort is dropped. The divider counter
  // is reused as the dwell timer.
  always_comb begin
    state_d      = state_q;
    mod_d        = mod_q;
    divCnt_d     = divCnt_q;
    stepCnt_d    = stepCnt_q;
    stepLatch_d  = stepLatch_q;
    stepsLatch_d = stepsLatch_q;
    done_d       = 1'b0;

    case (state_q)
      IDLE: begin
        mod_d = '0;
        if (sweep_start && !sweep_abort) begin
          if (sweep_steps != 16'd0) begin
            state_d      = RAMP;
            stepLatch_d  = sweep_step;
            stepsLatch_d = sweep_steps;
            divCnt_d     = '0;
            stepCnt_d    = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end

      RAMP: begin
        if (sweep_abort) begin
          state_d   = IDLE;
          mod_d     = '0;
          divCnt_d  = '0;
          stepCnt_d = '0;
        end else if (divCnt_q == DIV_LAST) begin
          divCnt_d  = '0;
          mod_d     = mod_q + stepLatch_q;
          stepCnt_d = stepCnt_q + 16'd1;
          if (stepCnt_q + 16'd1 == stepsLatch_q) begin
            state_d = DWELL;
          end
        end else begin
          divCnt_d = divCnt_q + 32'd1;
        end
      end

      DWELL: begin
        if (sweep_abort) begin
          state_d   = IDLE;
          mod_d     = '0;
          divCnt_d  = '0;
          stepCnt_d = '0;
        end else if (divCnt_q == DWELL_LAST) begin
          state_d   = IDLE;
          mod_d     = '0;
          divCnt_d  = '0;
          stepCnt_d = '0;
          done_d    = 1'b1;
        end else begin
          divCnt_d = divCnt_q + 32'd1;
        end
      end

      default: begin
        state_d = IDLE;
        mod_d   = '0;
      end
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign sig      = sig_q;
  assign sync     = sig_q & ~sigPrev_q;
  assign incr_out = incr_q;

endmodule
